// File: rtl/multiplicador_secuencial_if.sv
// Handshake and operand bus of the sequential shift-add multiplier.
interface multiplicador_secuencial_if #(
    parameter int ANCHO = 8
);
    logic                 Inicio;
    logic [ANCHO-1:0]     X;
    logic [ANCHO-1:0]     Y;
    logic                 Ocupado;
    logic                 Listo;
    logic [2*ANCHO-1:0]   Salida;

    modport master (output Inicio, X, Y, input  Ocupado, Listo, Salida);
    modport slave  (input  Inicio, X, Y, output Ocupado, Listo, Salida);
endinterface

// File: rtl/multiplicador_secuencial.sv
// Sequential shift-add multiplier, one multiplier bit per cycle, REPOSO/CALCULO/FIN FSM.
// Define MULT_CON_SIGNO_EN for two's-complement operands and product.
module multiplicador_secuencial #(
    parameter int ANCHO = 8
) (
    input  logic                          Clk,
    input  logic                          Rst_n,
    multiplicador_secuencial_if.slave     bus
);
    localparam int CW = $clog2(ANCHO);

    typedef enum logic [1:0] {
        REPOSO  = 2'd0,
        CALCULO = 2'd1,
        FIN     = 2'd2
    } estado_t;

    estado_t              estado, estado_sig;
    logic [2*ANCHO-1:0]   mcand, acc, suma, producto, salida;
    logic [ANCHO-1:0]     mplier, mag_x, mag_y;
    logic [CW-1:0]        cnt;
    logic                 arranque, ultimo, ocupado, listo;

`ifdef MULT_CON_SIGNO_EN
    logic negativo;

    // Multiply magnitudes; the sign is applied once to the finished product.
    assign mag_x    = bus.X[ANCHO-1] ? -bus.X : bus.X;
    assign mag_y    = bus.Y[ANCHO-1] ? -bus.Y : bus.Y;
    assign producto = negativo ? -suma : suma;

    always_ff @(posedge Clk) begin
        if (!Rst_n)        negativo <= 1'b0;
        else if (arranque) negativo <= bus.X[ANCHO-1] ^ bus.Y[ANCHO-1];
    end
`else
    assign mag_x    = bus.X;
    assign mag_y    = bus.Y;
    assign producto = suma;
`endif

    assign arranque = bus.Inicio && (estado == REPOSO || estado == FIN);
    assign ultimo   = (cnt == CW'(ANCHO - 1));
    assign suma     = mplier[0] ? acc + mcand : acc;

    always_comb begin
        estado_sig = REPOSO;
        ocupado    = 1'b0;
        listo      = 1'b0;
        case (estado)
            REPOSO:  estado_sig = bus.Inicio ? CALCULO : REPOSO;
            CALCULO: begin
                ocupado    = 1'b1;
                estado_sig = ultimo ? FIN : CALCULO;
            end
            FIN: begin
                listo      = 1'b1;
                estado_sig = bus.Inicio ? CALCULO : REPOSO;
            end
            default: estado_sig = REPOSO;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            estado <= REPOSO;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
            salida <= '0;
        end else begin
            estado <= estado_sig;
            if (arranque) begin
                mcand  <= {{ANCHO{1'b0}}, mag_x};
                mplier <= mag_y;
                acc    <= '0;
                cnt    <= '0;
            end else if (estado == CALCULO) begin
                acc    <= suma;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt + 1'b1;
                // The final partial sum is folded in as the result is captured.
                if (ultimo) salida <= producto;
            end
        end
    end

    assign bus.Ocupado = ocupado;
    assign bus.Listo   = listo;
    assign bus.Salida  = salida;
endmodule

// File: tb/tb_multiplicador_secuencial.sv
// Directed bench: 8-bit vector table plus multi-cycle corner cases, and a 4-bit exhaustive sweep.
module tb_multiplicador_secuencial;
    logic clk;
    logic rst_n;

    multiplicador_secuencial_if #(.ANCHO(8)) if8 ();
    multiplicador_secuencial_if #(.ANCHO(4)) if4 ();

    multiplicador_secuencial #(.ANCHO(8)) dut8 (.Clk(clk), .Rst_n(rst_n), .bus(if8.slave));
    multiplicador_secuencial #(.ANCHO(4)) dut4 (.Clk(clk), .Rst_n(rst_n), .bus(if4.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  x;
        logic [7:0]  y;
        logic [15:0] p;
    } vec_t;

    int checks = 0;
    int passed = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    // Starts a product one step after an edge; scrambles X/Y once accepted.
    task automatic op8(input logic [7:0] x, input logic [7:0] y,
                       output logic [15:0] res, output int lat, output int busy);
        if8.X = x; if8.Y = y; if8.Inicio = 1'b1;
        lat = 0; busy = 0;
        do begin
            @(posedge clk); #1;
            lat++;
            if (lat == 1) begin
                if8.Inicio = 1'b0; if8.X = ~x; if8.Y = ~y;
            end
            if (if8.Ocupado) busy++;
        end while (!if8.Listo && lat < 40);
        res = if8.Salida;
    endtask

    task automatic op4(input logic [3:0] x, input logic [3:0] y,
                       output logic [7:0] res, output int lat);
        if4.X = x; if4.Y = y; if4.Inicio = 1'b1;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
            if (lat == 1) if4.Inicio = 1'b0;
        end while (!if4.Listo && lat < 40);
        res = if4.Salida;
    endtask

    initial begin
        vec_t        tabla [7];
        logic [15:0] res;
        logic [7:0]  res4;
        int          lat, busy, pulsos;

`ifdef MULT_CON_SIGNO_EN
        tabla[0] = '{8'hFF, 8'hFF, 16'h0001};
        tabla[1] = '{8'h80, 8'h7F, 16'hC080};
        tabla[2] = '{8'h80, 8'h80, 16'h4000};
        tabla[3] = '{8'h0F, 8'h0F, 16'h00E1};
        tabla[4] = '{8'h00, 8'hA5, 16'h0000};
        tabla[5] = '{8'hFF, 8'h01, 16'hFFFF};
        tabla[6] = '{8'hFE, 8'h03, 16'hFFFA};
`else
        tabla[0] = '{8'h0F, 8'h0F, 16'h00E1};
        tabla[1] = '{8'hFF, 8'hFF, 16'hFE01};
        tabla[2] = '{8'h00, 8'hA5, 16'h0000};
        tabla[3] = '{8'hA5, 8'h00, 16'h0000};
        tabla[4] = '{8'h80, 8'h02, 16'h0100};
        tabla[5] = '{8'h01, 8'hFF, 16'h00FF};
        tabla[6] = '{8'h04, 8'h05, 16'h0014};
`endif

        // Reset with Inicio held high: nothing may start.
        rst_n = 1'b0;
        if8.Inicio = 1'b1; if8.X = 8'h12; if8.Y = 8'h34;
        if4.Inicio = 1'b1; if4.X = 4'h3;  if4.Y = 4'h5;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ocupado", {31'b0, if8.Ocupado}, 32'd0);
        chk("rst_listo",   {31'b0, if8.Listo},   32'd0);
        chk("rst_salida",  {16'b0, if8.Salida},  32'd0);
        chk("rst_salida4", {24'b0, if4.Salida},  32'd0);
        if8.Inicio = 1'b0; if4.Inicio = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("idle_ocupado", {31'b0, if8.Ocupado}, 32'd0);

        foreach (tabla[i]) begin
            op8(tabla[i].x, tabla[i].y, res, lat, busy);
            chk($sformatf("vec%0d_salida", i), {16'b0, res}, {16'b0, tabla[i].p});
            chk($sformatf("vec%0d_latencia", i), lat, 32'd9);
            chk($sformatf("vec%0d_ocupado", i), busy, 32'd8);
            @(posedge clk); #1;
            chk($sformatf("vec%0d_listo_pulso", i), {31'b0, if8.Listo}, 32'd0);
            chk($sformatf("vec%0d_salida_estable", i), {16'b0, if8.Salida}, {16'b0, tabla[i].p});
        end

        // Inicio re-raised with new operands mid-computation, then held through FIN.
        if8.X = 8'h04; if8.Y = 8'h05; if8.Inicio = 1'b1;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
            if (lat == 1) if8.Inicio = 1'b0;
            if (lat == 3) begin
                if8.Inicio = 1'b1; if8.X = 8'h02; if8.Y = 8'h03;
            end
        end while (!if8.Listo && lat < 40);
        chk("b2b_primero_latencia", lat, 32'd9);
        chk("b2b_primero_salida", {16'b0, if8.Salida}, 32'h0014);
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
            if (lat == 1) begin
                if8.Inicio = 1'b0;
                chk("b2b_ocupado_tras_fin", {31'b0, if8.Ocupado}, 32'd1);
            end
        end while (!if8.Listo && lat < 40);
        chk("b2b_segundo_latencia", lat, 32'd9);
        chk("b2b_segundo_salida", {16'b0, if8.Salida}, 32'h0006);
        @(posedge clk); #1;

        // Reset pulse during the 4th CALCULO cycle aborts the product.
        if8.X = 8'h33; if8.Y = 8'h11; if8.Inicio = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(posedge clk); #1;
            if (c == 1) if8.Inicio = 1'b0;
        end
        chk("abort_ocupado_antes", {31'b0, if8.Ocupado}, 32'd1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("abort_ocupado", {31'b0, if8.Ocupado}, 32'd0);
        chk("abort_listo",   {31'b0, if8.Listo},   32'd0);
        chk("abort_salida",  {16'b0, if8.Salida},  32'd0);
        pulsos = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (if8.Listo) pulsos++;
        end
        chk("abort_sin_listo", pulsos, 32'd0);
        op8(8'h33, 8'h11, res, lat, busy);
        chk("abort_siguiente_salida", {16'b0, res}, 32'h0363);
        chk("abort_siguiente_latencia", lat, 32'd9);
        @(posedge clk); #1;

        // Exhaustive 4-bit sweep.
        for (int x = 0; x < 16; x++) begin
            for (int y = 0; y < 16; y++) begin
                int sx, sy, prod;
`ifdef MULT_CON_SIGNO_EN
                sx = (x >= 8) ? x - 16 : x;
                sy = (y >= 8) ? y - 16 : y;
`else
                sx = x;
                sy = y;
`endif
                prod = sx * sy;
                op4(4'(x), 4'(y), res4, lat);
                chk($sformatf("ancho4_%0d_x_%0d", x, y), {24'b0, res4}, {24'b0, prod[7:0]});
                if (lat != 5) chk($sformatf("ancho4_latencia_%0d_%0d", x, y), lat, 32'd5);
                @(posedge clk); #1;
            end
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
